// File: rtl/call_register.sv
// call_register: synchronises and debounces three active-low buttons, latches one
// pending request per floor and picks the next target floor with a SCAN policy.
module call_register #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       floor1,
  input  logic       floor2,
  input  logic       floor3,
  input  logic       door,
  output logic       req1,
  output logic       req2,
  output logic       req3,
  output logic [1:0] target,
  output logic       target_valid,
  output logic       dir_up
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [2:0] btn_raw, sync1, sync2, db, press;
  logic [7:0] cnt [0:2];
  logic [2:0] flr, req;
  logic [1:0] cur, up_pick, dn_pick, tgt_nxt;
  logic       dir_nxt;

  assign btn_raw = {button3, button2, button1};
  assign flr     = {floor3, floor2, floor1};

  // A press pulse is emitted only on the debounced released->pressed transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      db    <= 3'b111;
      press <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= 8'd0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= 8'd0;
        end else if (cnt[i] + 8'd1 == DB_LIMIT) begin
          db[i]    <= sync2[i];
          cnt[i]   <= 8'd0;
          press[i] <= db[i];
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Clear beats set, so a press at the open-door floor is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req <= 3'b000;
    else     req <= (req | press) & ~({3{door}} & flr);
  end

  assign req1 = req[0];
  assign req2 = req[1];
  assign req3 = req[2];

  always_comb begin
    cur = 2'd0;
    case (flr)
      3'b001:  cur = 2'd1;
      3'b010:  cur = 2'd2;
      3'b100:  cur = 2'd3;
      default: cur = 2'd0;
    endcase
  end

  always_comb begin
    up_pick = 2'd0;
    dn_pick = 2'd0;
    case (cur)
      2'd1: up_pick = req[1] ? 2'd2 : (req[2] ? 2'd3 : 2'd0);
      2'd2: begin
        up_pick = req[2] ? 2'd3 : 2'd0;
        dn_pick = req[0] ? 2'd1 : 2'd0;
      end
      2'd3: dn_pick = req[1] ? 2'd2 : (req[0] ? 2'd1 : 2'd0);
      default: ;
    endcase
  end

  // cur==0 means the floor inputs are not one-hot: hold everything.
  always_comb begin
    tgt_nxt = target;
    dir_nxt = dir_up;
    if (cur != 2'd0) begin
      if (|(req & flr) && !door) tgt_nxt = cur;
      else if (dir_up)           tgt_nxt = (up_pick != 2'd0) ? up_pick : dn_pick;
      else                       tgt_nxt = (dn_pick != 2'd0) ? dn_pick : up_pick;
      if (tgt_nxt != 2'd0 && tgt_nxt > cur)      dir_nxt = 1'b1;
      else if (tgt_nxt != 2'd0 && tgt_nxt < cur) dir_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target       <= 2'd0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
    end else begin
      target       <= tgt_nxt;
      target_valid <= (tgt_nxt != 2'd0);
      dir_up       <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_call_register.sv
// Bench for call_register: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of requests and SCAN selection.
module tb_call_register;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] fl;
  logic       door;
  logic       req1, req2, req3;
  logic [1:0] target;
  logic       target_valid, dir_up;

  int n_chk = 0;
  int n_pass = 0;

  logic [2:0] m_req;
  logic [1:0] m_tgt;
  logic       m_dir;
  int         cd [3];

  call_register #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .button1(btn[0]), .button2(btn[1]), .button3(btn[2]),
    .floor1(fl[0]), .floor2(fl[1]), .floor3(fl[2]),
    .door(door),
    .req1(req1), .req2(req2), .req3(req3),
    .target(target), .target_valid(target_valid), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  function automatic void ref_scan(input logic [2:0] r, input int cur, input logic dr,
                                   inout logic [1:0] t, inout logic d);
    int above, below, pick;
    above = 0;
    below = 0;
    for (int f = 1; f <= 3; f++) begin
      if (r[f-1] && f > cur && above == 0) above = f;
      if (r[f-1] && f < cur) below = f;
    end
    if (r[cur-1] && !dr) pick = cur;
    else if (d)          pick = (above != 0) ? above : below;
    else                 pick = (below != 0) ? below : above;
    if (pick != 0 && pick > cur)      d = 1'b1;
    else if (pick != 0 && pick < cur) d = 1'b0;
    t = 2'(pick);
  endfunction

  task automatic model_reset();
    m_req = 3'b000;
    m_tgt = 2'd0;
    m_dir = 1'b1;
    for (int b = 0; b < 3; b++) cd[b] = 0;
  endtask

  // Advance the model by one clock edge, then let the DUT take the same edge.
  task automatic step();
    logic [2:0] pm;
    logic [1:0] t;
    logic       d;
    int         cur;
    pm = 3'b000;
    for (int b = 0; b < 3; b++)
      if (cd[b] > 0) begin
        cd[b]--;
        if (cd[b] == 0) pm[b] = 1'b1;
      end
    if ($countones(fl) == 1) begin
      cur = fl[0] ? 1 : (fl[1] ? 2 : 3);
      t = m_tgt;
      d = m_dir;
      ref_scan(m_req, cur, door, t, d);
      m_tgt = t;
      m_dir = d;
    end
    m_req = (m_req | pm) & ~(door ? fl : 3'b000);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input int hold, input int rel);
    btn[b] = 1'b0;
    cd[b]  = D + 3;
    repeat (hold) step();
    btn[b] = 1'b1;
    repeat (rel) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 3'b111;
    fl = 3'b001;
    door = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++;
    if ({req3, req2, req1} !== 3'b000 || target !== 2'd0 || target_valid !== 1'b0 || dir_up !== 1'b1)
      $display("FAIL reset_initial: req=%b tgt=%0d v=%b dir=%b expected 000/0/0/1",
               {req3, req2, req1}, target, target_valid, dir_up);
    else n_pass++;
    fl = 3'b100;
    press(0, D + 4, D + 4);
    n_chk++;
    if ({req3, req2, req1} !== m_req || target !== m_tgt || dir_up !== m_dir)
      $display("FAIL reset_setup: req=%b tgt=%0d dir=%b expected req=%b tgt=%0d dir=%b",
               {req3, req2, req1}, target, dir_up, m_req, m_tgt, m_dir);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if ({req3, req2, req1} !== 3'b000 || target !== 2'd0 || target_valid !== 1'b0 || dir_up !== 1'b1)
      $display("FAIL reset_async: req=%b tgt=%0d v=%b dir=%b expected 000/0/0/1",
               {req3, req2, req1}, target, target_valid, dir_up);
    else n_pass++;
    model_reset();
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_chk++;
      if ({req3, req2, req1} !== m_req || target !== m_tgt || target_valid !== (m_tgt != 2'd0) || dir_up !== m_dir)
        $display("FAIL reset_hold c=%0d: req=%b tgt=%0d v=%b dir=%b expected req=%b tgt=%0d dir=%b",
                 c, {req3, req2, req1}, target, target_valid, dir_up, m_req, m_tgt, m_dir);
      else n_pass++;
    end
    // Reset in the middle of a debounce window, button released at the same time.
    btn[1] = 1'b0;
    cd[1] = D + 3;
    repeat (3) step();
    #3 rst = 1'b1;
    btn[1] = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    for (int c = 0; c < D + 6; c++) begin
      step();
      n_chk++;
      if ({req3, req2, req1} !== 3'b000 || {req3, req2, req1} !== m_req)
        $display("FAIL reset_mid_debounce c=%0d: req=%b expected 000", c, {req3, req2, req1});
      else n_pass++;
    end
  endtask

  task automatic test_debounce_reject();
    fl = 3'b001;
    door = 1'b0;
    btn[1] = 1'b0;
    repeat (2) step();
    btn[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 12) btn[1] = c[0];
      else        btn[1] = 1'b1;
      step();
      n_chk++;
      if (req2 !== 1'b0 || {req3, req2, req1} !== m_req || target !== m_tgt)
        $display("FAIL debounce_reject c=%0d: req=%b tgt=%0d expected req=%b tgt=%0d",
                 c, {req3, req2, req1}, target, m_req, m_tgt);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    fl = 3'b001;
    door = 1'b0;
    btn[2] = 1'b0;
    cd[2] = D + 3;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_chk++;
      if ({req3, req2, req1} !== m_req || target !== m_tgt || dir_up !== m_dir)
        $display("FAIL latency_model e=%0d: req=%b tgt=%0d dir=%b expected req=%b tgt=%0d dir=%b",
                 e, {req3, req2, req1}, target, dir_up, m_req, m_tgt, m_dir);
      else n_pass++;
      if (e == D + 2 || e == D + 3) begin
        n_chk++;
        if (req3 !== (e == D + 3))
          $display("FAIL latency_edge e=%0d: req3=%b expected %b", e, req3, (e == D + 3));
        else n_pass++;
      end
      if (e == D + 4) begin
        n_chk++;
        if (target !== 2'd3 || target_valid !== 1'b1 || dir_up !== 1'b1)
          $display("FAIL latency_target: tgt=%0d v=%b dir=%b expected 3/1/1", target, target_valid, dir_up);
        else n_pass++;
      end
    end
    btn[2] = 1'b1;
    repeat (D + 4) step();
  endtask

  task automatic test_service_clear();
    fl = 3'b001;
    door = 1'b0;
    press(1, D + 4, D + 4);
    fl = 3'b010;
    door = 1'b1;
    step();
    n_chk++;
    if (req2 !== 1'b0 || {req3, req2, req1} !== m_req)
      $display("FAIL service_clear: req=%b expected req2=0 req=%b", {req3, req2, req1}, m_req);
    else n_pass++;
    btn[1] = 1'b0;
    cd[1] = D + 3;
    for (int c = 0; c < D + 5; c++) begin
      step();
      n_chk++;
      if (req2 !== 1'b0 || {req3, req2, req1} !== m_req || target !== m_tgt)
        $display("FAIL service_collision c=%0d: req=%b tgt=%0d expected req=%b tgt=%0d",
                 c, {req3, req2, req1}, target, m_req, m_tgt);
      else n_pass++;
    end
    btn[1] = 1'b1;
    repeat (D + 4) step();
    door = 1'b0;
  endtask

  task automatic test_scan_order();
    fl = 3'b010;
    door = 1'b0;
    press(0, D + 4, D + 4);
    n_chk++;
    if ({req3, req2, req1} !== 3'b101 || target !== 2'd3 || dir_up !== 1'b1 || target !== m_tgt)
      $display("FAIL scan_up: req=%b tgt=%0d dir=%b expected 101/3/1", {req3, req2, req1}, target, dir_up);
    else n_pass++;
    fl = 3'b100;
    door = 1'b1;
    repeat (2) step();
    n_chk++;
    if (req3 !== 1'b0 || target !== 2'd1 || dir_up !== 1'b0 || dir_up !== m_dir)
      $display("FAIL scan_reverse: req3=%b tgt=%0d dir=%b expected 0/1/0", req3, target, dir_up);
    else n_pass++;
    door = 1'b0;
  endtask

  task automatic test_non_onehot();
    logic [1:0] t_hold;
    logic       d_hold;
    fl = 3'b001;
    door = 1'b1;
    repeat (2) step();
    door = 1'b0;
    press(2, D + 4, D + 4);
    t_hold = m_tgt;
    d_hold = m_dir;
    fl = 3'b000;
    press(0, D + 4, 2);
    n_chk++;
    if (req1 !== 1'b1 || target !== t_hold || dir_up !== d_hold || t_hold !== 2'd3)
      $display("FAIL nonhot_hold: req1=%b tgt=%0d dir=%b expected 1/%0d/%b",
               req1, target, dir_up, t_hold, d_hold);
    else n_pass++;
    fl = 3'b011;
    repeat (D + 2) step();
    n_chk++;
    if (target !== t_hold || dir_up !== d_hold || target_valid !== 1'b1)
      $display("FAIL nonhot_multi: tgt=%0d dir=%b expected %0d/%b", target, dir_up, t_hold, d_hold);
    else n_pass++;
    fl = 3'b001;
    repeat (2) step();
    n_chk++;
    if (target !== m_tgt || dir_up !== m_dir || target !== 2'd1)
      $display("FAIL nonhot_resume: tgt=%0d dir=%b expected %0d/%b", target, dir_up, m_tgt, m_dir);
    else n_pass++;
  endtask

  task automatic test_random();
    int b, hold, sel;
    for (int it = 0; it < 40; it++) begin
      b = $urandom_range(0, 2);
      hold = D + 3 + $urandom_range(0, 3);
      btn[b] = 1'b0;
      cd[b] = D + 3;
      for (int c = 0; c < hold + D + 4; c++) begin
        if (c == hold) btn[b] = 1'b1;
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2: fl = 3'b001;
          3, 4:    fl = 3'b010;
          5, 6, 7: fl = 3'b100;
          8:       fl = 3'b000;
          default: fl = 3'b110;
        endcase
        door = ($urandom_range(0, 3) == 0);
        step();
        n_chk++;
        if ({req3, req2, req1} !== m_req || target !== m_tgt || target_valid !== (m_tgt != 2'd0) || dir_up !== m_dir)
          $display("FAIL random it=%0d c=%0d: req=%b tgt=%0d v=%b dir=%b expected req=%b tgt=%0d dir=%b",
                   it, c, {req3, req2, req1}, target, target_valid, dir_up, m_req, m_tgt, m_dir);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_reject();
    test_latency();
    test_service_clear();
    test_scan_order();
    test_non_onehot();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
